// File: rtl/spi_txn_sequencer_if.sv
// Host-side command/response handshake bundle for spi_txn_sequencer.
interface spi_txn_sequencer_if #(
    parameter int NBITS  = 8,
    parameter int NSLAVE = 4
);
    localparam int CSW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [NBITS-1:0] cmd_data;
    logic [CSW-1:0]   cmd_cs;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [NBITS-1:0] rsp_data;
    logic [CSW-1:0]   rsp_cs;

    modport master (
        output cmd_valid, cmd_data, cmd_cs, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_cs
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_cs, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_cs
    );
endinterface

// File: rtl/spi_txn_sequencer.sv
// Command/response sequencer feeding an SPI master: command FIFO in,
// one transfer in flight, response FIFO out.
module spi_txn_sequencer #(
    parameter int  NBITS  = 8,
    parameter int  NSLAVE = 4,
    parameter int  DEPTH  = 4,
    localparam int CSW    = (NSLAVE > 1) ? $clog2(NSLAVE) : 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    spi_txn_sequencer_if.slave host,
    input  logic             spi_ready,
    input  logic             spi_done_tick,
    input  logic [NBITS-1:0] spi_rx_data,
    output logic             spi_start,
    output logic [NBITS-1:0] spi_tx_data,
    output logic [CSW-1:0]   spi_cs_num,
    output logic             busy,
    output logic [AW:0]      cmd_count,
    output logic [AW:0]      rsp_count,
    output logic             err_stray_done
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    localparam logic [AW:0] PTR_ONE = 1;

    state_t state;

    logic [NBITS-1:0] cmd_mem_data [DEPTH];
    logic [CSW-1:0]   cmd_mem_cs   [DEPTH];
    logic [NBITS-1:0] rsp_mem_data [DEPTH];
    logic [CSW-1:0]   rsp_mem_cs   [DEPTH];

    logic [AW:0] cmd_wr, cmd_rd, rsp_wr, rsp_rd;
    logic        cmd_empty, cmd_full, rsp_empty, rsp_full;
    logic        cmd_push, rsp_push, rsp_pop, launch;

    // Pointers carry one wrap bit: equal means empty, wrap-only difference means full.
    assign cmd_empty = (cmd_wr == cmd_rd);
    assign cmd_full  = (cmd_wr == {~cmd_rd[AW], cmd_rd[AW-1:0]});
    assign rsp_empty = (rsp_wr == rsp_rd);
    assign rsp_full  = (rsp_wr == {~rsp_rd[AW], rsp_rd[AW-1:0]});
    assign cmd_count = cmd_wr - cmd_rd;
    assign rsp_count = rsp_wr - rsp_rd;

    assign host.cmd_ready = !cmd_full;
    assign host.rsp_valid = !rsp_empty;
    assign host.rsp_data  = rsp_empty ? '0 : rsp_mem_data[rsp_rd[AW-1:0]];
    assign host.rsp_cs    = rsp_empty ? '0 : rsp_mem_cs[rsp_rd[AW-1:0]];

    assign cmd_push = host.cmd_valid && !cmd_full;
    assign rsp_pop  = host.rsp_ready && !rsp_empty;
    assign rsp_push = (state == WAIT) && spi_done_tick;
    // A free response slot at launch guarantees the in-flight result fits.
    assign launch   = (state == IDLE) && !cmd_empty && spi_ready && !rsp_full;
    assign busy     = (state != IDLE) || !cmd_empty;

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem_data[cmd_wr[AW-1:0]] <= host.cmd_data;
            cmd_mem_cs[cmd_wr[AW-1:0]]   <= host.cmd_cs;
        end
        if (rsp_push) begin
            rsp_mem_data[rsp_wr[AW-1:0]] <= spi_rx_data;
            rsp_mem_cs[rsp_wr[AW-1:0]]   <= spi_cs_num;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_wr <= '0;
            cmd_rd <= '0;
            rsp_wr <= '0;
            rsp_rd <= '0;
        end else begin
            if (cmd_push) cmd_wr <= cmd_wr + PTR_ONE;
            if (launch)   cmd_rd <= cmd_rd + PTR_ONE;
            if (rsp_push) rsp_wr <= rsp_wr + PTR_ONE;
            if (rsp_pop)  rsp_rd <= rsp_rd + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            spi_start      <= 1'b0;
            spi_tx_data    <= '0;
            spi_cs_num     <= '0;
            err_stray_done <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            if (spi_done_tick && state != WAIT) err_stray_done <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        state       <= LAUNCH;
                        spi_start   <= 1'b1;
                        spi_tx_data <= cmd_mem_data[cmd_rd[AW-1:0]];
                        spi_cs_num  <= cmd_mem_cs[cmd_rd[AW-1:0]];
                    end
                end
                LAUNCH: state <= WAIT;
                WAIT: begin
                    if (spi_done_tick) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_txn_sequencer.md
# spi_txn_sequencer

Command/response sequencer that sits directly upstream of the SPI master wrapper and drives its start, tx_data and cs_num inputs. Host logic pushes (data, slave index) commands into a command FIFO; the sequencer launches them one at a time when the SPI master reports ready, captures rx_data on each spi_done_tick and queues (data, slave index) responses in a response FIFO for the host to pop. A command is never launched unless response space is available, so responses are never dropped.

## Interface
- NBITS, 8, bits per SPI transfer; matches the SPI master NBITS
- NSLAVE, 4, number of slaves; cs index width is $clog2(NSLAVE)
- DEPTH, 4, entries per FIFO; power of two, >= 2

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command FIFO not full (combinational from level)
- cmd_data  in  NBITS  byte to transmit
- cmd_cs  in  $clog2(NSLAVE)  target slave index
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  host pops response
- rsp_data  out  NBITS  received byte at head of response FIFO
- rsp_cs  out  $clog2(NSLAVE)  slave index the head response came from
- spi_ready  in  1  SPI master idle
- spi_done_tick  in  1  SPI master end-of-transfer pulse
- spi_rx_data  in  NBITS  SPI master received data
- spi_start  out  1  one-cycle start pulse to SPI master (registered)
- spi_tx_data  out  NBITS  data to SPI master (registered, held)
- spi_cs_num  out  $clog2(NSLAVE)  slave index to SPI master (registered, held)
- busy  out  1  FSM not in IDLE or command FIFO non-empty
- cmd_count  out  $clog2(DEPTH)+1  command FIFO occupancy, 0..DEPTH
- rsp_count  out  $clog2(DEPTH)+1  response FIFO occupancy, 0..DEPTH
- err_stray_done  out  1  sticky: spi_done_tick seen outside WAIT

## Operation
- Two FIFOs, DEPTH entries each, read/write pointers with one extra wrap bit; full when pointers differ only in the wrap bit, empty when equal. Wrap from DEPTH-1 to 0.
- Command push on cmd_valid && cmd_ready; push while full is impossible (cmd_ready low). Simultaneous push and FSM pop allowed at any level, including full (pop frees, push blocked that cycle since cmd_ready is from current level).
- Response push only in WAIT on spi_done_tick; response pop on rsp_valid && rsp_ready. Simultaneous push and pop keeps rsp_count unchanged.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE -> LAUNCH when cmd FIFO non-empty && spi_ready && rsp_count < DEPTH; on that edge pop command, load spi_tx_data/spi_cs_num, set spi_start.
  - LAUNCH -> WAIT unconditionally; clear spi_start.
  - WAIT -> IDLE on spi_done_tick; push {spi_cs_num, spi_rx_data} to response FIFO on that edge.
- rsp_count < DEPTH check at launch guarantees the single in-flight response has a slot (host pops can only increase room).
- spi_tx_data and spi_cs_num hold their value from launch until the next launch; never change during WAIT.
- spi_done_tick in IDLE or LAUNCH: ignored (no push), err_stray_done set; cleared only by reset.
- No timeout: WAIT persists until spi_done_tick or reset.

## Timing
- Reset values: spi_start 0, spi_tx_data 0, spi_cs_num 0, rsp_valid 0, rsp_data 0, rsp_cs 0, cmd_count 0, rsp_count 0, busy 0, err_stray_done 0, cmd_ready 1; FSM IDLE; FIFO contents don't-care.
- Reset asserted mid-transfer: FSM to IDLE, both FIFOs emptied, spi_start low immediately; in-flight response discarded; SPI master reset separately.
- Command accepted at edge k into empty FIFO with spi_ready high: IDLE->LAUNCH at edge k+1, spi_start high for exactly the cycle between edges k+1 and k+2.
- spi_done_tick sampled at edge m: response written at m, rsp_valid high after m, FSM IDLE after m; next spi_start earliest after edge m+1.
- Back-to-back throughput: one transfer per (SPI transfer length + 2) cycles of sequencer overhead.
- rsp_data/rsp_cs show FIFO head combinationally; valid only while rsp_valid.

## Test plan
- Push cmd (0xA5, cs 2), spi model returns 0x3C after 20 cycles -> one spi_start pulse with spi_tx_data=0xA5, spi_cs_num=2; rsp 0x3C/cs 2 one cycle after done tick; rsp_count=1.
- Push 5 cmds with spi_ready held low, DEPTH=4 -> cmd_ready low after 4th, cmd_count=4, 5th held; release spi_ready -> all 5 launched in order, responses in order.
- Host never pops, 6 cmds queued -> exactly 4 launches, then IDLE with cmd_count=2 and no spi_start; pop one rsp -> 5th launch on following cycle.
- Simultaneous rsp push and pop at rsp_count=4-1 and at 1 -> count unchanged, data order preserved across pointer wrap (>=10 transfers).
- spi_done_tick pulsed in IDLE -> err_stray_done=1, rsp_count unchanged; reset -> err_stray_done=0.
- reset asserted during WAIT with 3 queued cmds -> spi_start 0, cmd_count=0, rsp_count=0, busy=0; new cmd after reset launches normally.
